// File: rtl/alu_share_ctrl.sv
// Round-robin sequencer sharing one combinational ALU between two requesters.
// Operands are registered toward the ALU; the result returns one cycle later.
module alu_share_ctrl #(
    parameter int W    = 8,
    parameter int SELW = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [2*W-1:0]    req_a,
    input  logic [2*W-1:0]    req_b,
    input  logic [2*SELW-1:0] req_sel,
    output logic [1:0]        rsp_valid,
    input  logic [1:0]        rsp_ready,
    output logic [W-1:0]      rsp_r,
    output logic [W-1:0]      alu_a,
    output logic [W-1:0]      alu_b,
    output logic [SELW-1:0]   alu_sel,
    input  logic [W-1:0]      alu_r,
    output logic              busy,
    output logic [7:0]        op_count
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t state;
    state_t state_nx;

    logic prio;
    logic id;
    logic gnt;
    logic accept;
    logic release_rsp;

    always_comb begin
        state_nx    = state;
        gnt         = prio;
        accept      = 1'b0;
        release_rsp = 1'b0;
        req_ready   = 2'b00;
        rsp_valid   = 2'b00;
        unique case (state)
            IDLE: begin
                // Fall back to the other side only when prio is idle.
                gnt    = req_valid[prio] ? prio : ~prio;
                accept = req_valid[gnt];
                if (accept) begin
                    req_ready = 2'b01 << gnt;
                    state_nx  = EXEC;
                end
            end
            EXEC: state_nx = RESP;
            RESP: begin
                rsp_valid = 2'b01 << id;
                if (rsp_ready[id]) begin
                    release_rsp = 1'b1;
                    state_nx    = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a    <= '0;
            alu_b    <= '0;
            alu_sel  <= '0;
            rsp_r    <= '0;
            prio     <= 1'b0;
            id       <= 1'b0;
            op_count <= '0;
        end else begin
            if (accept) begin
                alu_a   <= gnt ? req_a[W +: W] : req_a[0 +: W];
                alu_b   <= gnt ? req_b[W +: W] : req_b[0 +: W];
                alu_sel <= gnt ? req_sel[SELW +: SELW]
                               : req_sel[0 +: SELW];
                id      <= gnt;
                prio    <= ~gnt;
            end
            if (state == EXEC)
                rsp_r <= alu_r;
            if (release_rsp)
                op_count <= op_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: random and directed traffic against a
// transaction-level model of arbitration, results and completion count.
module tb_alu_share_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic [5:0]  req_sel;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [7:0]  rsp_r;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [2:0]  alu_sel;
    logic [7:0]  alu_r;
    logic        busy;
    logic [7:0]  op_count;

    int n_chk  = 0;
    int n_pass = 0;

    // model: pending transaction view
    bit       m_known = 0;
    bit       m_busy;
    int       m_age;
    int       m_id;
    int       m_prio;
    int       m_cnt;
    bit [7:0] m_a, m_b, m_rsp;
    bit [2:0] m_sel;

    always #5 clk = ~clk;

    alu_share_ctrl #(.W(8), .SELW(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_sel   (req_sel),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_r     (rsp_r),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_sel   (alu_sel),
        .alu_r     (alu_r),
        .busy      (busy),
        .op_count  (op_count)
    );

    function automatic logic [7:0] alu_fn(logic [7:0] a, logic [7:0] b,
                                          logic [2:0] s);
        case (s)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return ~a;
            3'd6:    return a << 1;
            default: return b;
        endcase
    endfunction

    always_comb alu_r = alu_fn(alu_a, alu_b, alu_sel);

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int pick(logic [1:0] v);
        if (v[m_prio]) return m_prio;
        if (v[1-m_prio]) return 1 - m_prio;
        return -1;
    endfunction

    task automatic step(input logic r, input logic [1:0] v,
                        input logic [15:0] a, input logic [15:0] b,
                        input logic [5:0] s, input logic [1:0] rr);
        int g;
        logic [1:0] e_rdy, e_rv;
        @(negedge clk);
        rst = r; req_valid = v; req_a = a; req_b = b;
        req_sel = s; rsp_ready = rr;
        #1;
        g = pick(v);
        if (m_known) begin
            e_rdy = (!m_busy && g >= 0) ? (2'b01 << g) : 2'b00;
            e_rv  = (m_busy && m_age == 1) ? (2'b01 << m_id) : 2'b00;
            chk("busy", {31'b0, busy}, {31'b0, m_busy});
            chk("req_ready", {30'b0, req_ready}, {30'b0, e_rdy});
            chk("rsp_valid", {30'b0, rsp_valid}, {30'b0, e_rv});
            chk("rsp_r", {24'b0, rsp_r}, {24'b0, m_rsp});
            chk("alu_a", {24'b0, alu_a}, {24'b0, m_a});
            chk("alu_b", {24'b0, alu_b}, {24'b0, m_b});
            chk("alu_sel", {29'b0, alu_sel}, {29'b0, m_sel});
            chk("op_count", {24'b0, op_count}, m_cnt);
        end
        // what the coming rising edge does
        if (r) begin
            m_known = 1; m_busy = 0; m_age = 0; m_id = 0; m_prio = 0;
            m_cnt = 0; m_a = 0; m_b = 0; m_sel = 0; m_rsp = 0;
        end else if (m_known) begin
            if (!m_busy) begin
                if (g >= 0) begin
                    m_busy = 1; m_age = 0; m_id = g; m_prio = 1 - g;
                    m_a = a[g*8 +: 8]; m_b = b[g*8 +: 8];
                    m_sel = s[g*3 +: 3];
                end
            end else if (m_age == 0) begin
                m_age = 1;
                m_rsp = alu_fn(m_a, m_b, m_sel);
            end else if (rr[m_id]) begin
                m_busy = 0;
                m_cnt = (m_cnt + 1) % 256;
            end
        end
    endtask

    initial begin
        logic [7:0] rq[$];
        logic [1:0] gq[$];
        int gt[$];
        bit wrap;
        logic [7:0] prev;
        rst = 1; req_valid = 0; req_a = 0; req_b = 0;
        req_sel = 0; rsp_ready = 0;

        // 1: reset with random inputs
        repeat (2) step(1, 2'($urandom), 16'($urandom), 16'($urandom),
                        6'($urandom), 2'($urandom));
        step(0, 0, 0, 0, 0, 0);
        chk("t1_busy", {31'b0, busy}, 0);
        chk("t1_req_ready", {30'b0, req_ready}, 0);
        chk("t1_op_count", {24'b0, op_count}, 0);

        // 2: single add
        step(0, 2'b01, 16'h0012, 16'h0005, 6'd0, 2'b01);
        chk("t2_req_ready", {30'b0, req_ready}, 2'b01);
        step(0, 0, 0, 0, 0, 2'b01);
        chk("t2_alu_a", {24'b0, alu_a}, 8'h12);
        chk("t2_alu_b", {24'b0, alu_b}, 8'h05);
        step(0, 0, 0, 0, 0, 2'b01);
        chk("t2_rsp_valid", {30'b0, rsp_valid}, 2'b01);
        chk("t2_rsp_r", {24'b0, rsp_r}, 8'h17);
        step(0, 0, 0, 0, 0, 2'b01);
        chk("t2_op_count", {24'b0, op_count}, 1);

        // 3: contention after reset, alternating grants
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) begin
            step(0, 2'b11, 16'h0201, 16'h0000, 6'd0, 2'b11);
            if (req_ready != 0) begin gq.push_back(req_ready); gt.push_back(i); end
            if (rsp_valid != 0) rq.push_back(rsp_r);
        end
        chk("t3_ngrant", gq.size(), 4);
        chk("t3_nrsp", rq.size(), 4);
        for (int i = 0; i < 4 && i < gq.size() && i < rq.size(); i++) begin
            chk("t3_grant", {30'b0, gq[i]}, (i % 2) ? 2'b10 : 2'b01);
            chk("t3_rsp", {24'b0, rq[i]}, (i % 2) ? 8'd2 : 8'd1);
            if (i > 0) chk("t3_spacing", gt[i] - gt[i-1], 3);
        end

        // 4: backpressure on requester 1
        step(0, 0, 0, 0, 0, 0);
        step(0, 2'b10, 16'hF000, 16'h0F00, 6'd0, 2'b00);
        chk("t4_accept", {30'b0, req_ready}, 2'b10);
        step(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 2'b11, 16'h1111, 16'h2222, 6'd0, 2'b00);
            chk("t4_rsp_valid", {30'b0, rsp_valid}, 2'b10);
            chk("t4_rsp_r", {24'b0, rsp_r}, 8'hFF);
            chk("t4_req_ready", {30'b0, req_ready}, 0);
        end
        step(0, 0, 0, 0, 0, 2'b10);
        step(0, 0, 0, 0, 0, 0);
        chk("t4_idle", {31'b0, busy}, 0);

        // 5: reset during EXEC
        step(0, 2'b01, 16'h0033, 16'h0044, 6'd0, 2'b11);
        step(1, 0, 0, 0, 0, 2'b11);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0, 2'b11);
            chk("t5_no_rsp", {30'b0, rsp_valid}, 0);
        end
        step(0, 2'b11, 16'h0201, 0, 0, 2'b11);
        chk("t5_grant0", {30'b0, req_ready}, 2'b01);

        // 6: counter wrap
        step(1, 0, 0, 0, 0, 0);
        wrap = 0;
        prev = op_count;
        for (int i = 0; i < 1000 && !wrap; i++) begin
            step(0, 2'b01, 16'($urandom), 16'($urandom), 6'($urandom), 2'b01);
            if (op_count != prev) begin
                if (prev == 8'd255 && op_count == 8'd0) wrap = 1;
                prev = op_count;
            end
        end
        chk("t6_wrap", {31'b0, wrap}, 1);

        // random traffic
        for (int i = 0; i < 600; i++)
            step(($urandom % 60) == 0, 2'($urandom), 16'($urandom),
                 16'($urandom), 6'($urandom), 2'($urandom));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/alu_share_ctrl.md
# alu_share_ctrl

Sequencer and round-robin arbiter that shares the single combinational ALU between two requesters, for example a host port and an internal sequencer. It accepts one operation at a time through valid/ready handshakes and drives the ALU operand/select bus from registers. It captures the ALU result one cycle later and returns it on a per-requester response handshake. It sits between the requesters and the ALU instance in the top level, replacing direct switch-to-ALU wiring.

## Interface
Parameters:
- W, 8, operand/result width
- SELW, 3, ALU operation-select width

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- req_valid  in  2  request valid, bit i = requester i
- req_ready  out  2  request accepted this cycle (one-hot or zero)
- req_a  in  2*W  operand A, requester i at [i*W +: W]
- req_b  in  2*W  operand B, same packing
- req_sel  in  2*SELW  ALU select, requester i at [i*SELW +: SELW]
- rsp_valid  out  2  result valid for requester i (one-hot or zero)
- rsp_ready  in  2  requester i consumes result
- rsp_r  out  W  result data, shared by both requesters
- alu_a  out  W  to ALU operand A (registered)
- alu_b  out  W  to ALU operand B (registered)
- alu_sel  out  SELW  to ALU select (registered)
- alu_r  in  W  from ALU result (combinational in ALU)
- busy  out  1  state != IDLE
- op_count  out  8  completed operations, wraps

## Operation
- States: IDLE, EXEC, RESP. Reset state is IDLE.
- Reset values: req_ready=00, rsp_valid=00, rsp_r=0, alu_a=0, alu_b=0, alu_sel=0, busy=0, op_count=0, priority pointer prio=0.
- IDLE:
  - grant g = prio if req_valid[prio], else the other requester if it is valid, else none.
  - req_ready = onehot(g), combinational from req_valid and prio. req_ready is 00 in every other state.
  - When req_valid[g] & req_ready[g]: register req_a/b/sel slice g into alu_a/b/sel, store id=g, set prio = ~g, go to EXEC.
- EXEC (exactly 1 cycle): capture alu_r into the result register (rsp_r), go to RESP.
- RESP:
  - rsp_valid[id]=1; rsp_r holds the result.
  - On rsp_ready[id]=1: rsp_valid becomes 00 next cycle, op_count increments, go to IDLE.
  - rsp_ready[~id] is ignored.
- alu_a/b/sel hold the last issued operation when IDLE and never glitch between operations. The sel code is forwarded unchanged; its meaning is defined by the ALU.
- op_count is an 8-bit modulo counter: 255 + 1 -> 0.
- Invariants:
  - A requester dropping req_valid while not granted has no effect.
  - Requester inputs are not sampled outside the accept cycle.

## Timing
- Accept at edge N. alu_* are valid after N. rsp_r is captured at N+1. rsp_valid is high from N+1 to N+2 onward.
- With rsp_ready held high: rsp_valid stays high for 1 cycle, IDLE is re-entered after edge N+2, and the next accept occurs at N+3. Peak throughput is 1 operation per 3 cycles.
- Backpressure: rsp_valid, rsp_r and id stay stable for any number of cycles until rsp_ready[id]. No new request is accepted meanwhile.
- Both requesters valid continuously: grants alternate strictly.
- Single requester: it is granted regardless of prio, and prio then points to the other requester.
- rst asserted in any state: next cycle all outputs take their reset values and any in-flight operation is dropped without a response. rst has priority over any handshake in the same cycle.
- No combinational path exists from rsp_ready to req_ready within the same cycle. Only the state transition links them.

## Test plan
1. Reset: hold rst 2 cycles with random inputs -> all outputs at reset values, busy=0, req_ready=00.
2. Single op: bench ALU model with sel 000 = add; req0 with a=0x12, b=0x05, sel=000, rsp_ready=01 -> req_ready=01 at accept, alu_a=0x12 and alu_b=0x05 after N, rsp_valid=01 with rsp_r=0x17 after N+1, op_count=1.
3. Contention: req_valid=11 held and rsp_ready=11; requester 0 has a=1 and requester 1 has a=2, both with b=0 and sel add -> grant order 0,1,0,1, accepts every 3 cycles, rsp_r sequence 1,2,1,2.
4. Backpressure: req1 with a=0xF0, b=0x0F, sel add, rsp_ready=00 for 5 cycles then 10 -> rsp_valid=10 and rsp_r=0xFF stable for all 5 cycles, req_ready=00 throughout, IDLE on the cycle after release.
5. Reset mid-operation: assert rst during EXEC -> no rsp_valid ever asserted for that operation, prio=0; the next concurrent request is granted to requester 0.
6. Counter wrap: 256 back-to-back operations -> op_count reads 255 and then 0.
